alu_arbiter: RTL and testbench

//  Shares the single multi-cycle ALU (op/start/done handshake) among NREQ requesters,
//  e.g. the control unit's EXECUTE stage and the address-generation path.

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu_arbiter_rr_pick.sv | 35 +++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter.
//   DATA_W_DEF  default operand/result width
//   OP_*        ALU op codes (1xx codes are passed through untouched)
//   state_t     arbiter FSM states
package alu_arb_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    request vector, NREQ bits
//   ptr    index with highest priority this cycle
//   grant  one-hot winner (all zero when no request)
//   idx    binary index of the winner
//   any    at least one request present
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Scan ptr, ptr+1, ... wrapping; the first set request wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU among NREQ requesters.
// Round-robin grant, one operation in flight, result routed back to its owner.
//
// Handshake: a requester holds req_valid (and its op/operands) until it sees
// req_ready in the same cycle; a transfer happens on the clock edge where both
// are high. Towards the ALU, alu_start is held with stable operands until
// alu_done is sampled high. The owner gets a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/op/a/b      per-requester request, op 3 bits, operands DATA_W
//   req_ready             one-hot combinational accept strobe
//   rsp_valid/data/err    one-hot result pulse, result, timeout-abort flag
//   alu_op/a/b/start      registered command to the ALU
//   alu_done/alu_out      ALU completion and result
//   busy                  FSM not idle
//
// Build option ALU_ARB_TIMEOUT_EN: abort an operation that has not completed
// after TIMEOUT cycles in EXEC (result 0, rsp_err 1). Without it EXEC waits
// forever and rsp_err is constant 0.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic [2:0]           alu_op,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state, state_nx;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [NREQ-1:0]   pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic              accept;
    logic              timeout_hit;
    logic [PTR_W-1:0]  rr_next;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gating with reset keeps req_ready low while reset is held, even if a
    // requester already has req_valid up.
    assign req_ready = (state == ST_IDLE && !reset && pick_any) ? pick_grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign rr_next   = PTR_W'((int'(pick_idx) + 1) % NREQ);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP) ? (NREQ'(1) << owner) : '0;

    always_comb begin
        sel_op = req_op[3*int'(pick_idx) +: 3];
        sel_a  = req_a[DATA_W*int'(pick_idx) +: DATA_W];
        sel_b  = req_b[DATA_W*int'(pick_idx) +: DATA_W];
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] exec_cnt;
    logic             rsp_err_q;

    // exec_cnt is 0 in the first EXEC cycle; alu_done in the last allowed
    // cycle takes priority over the abort.
    assign timeout_hit = (state == ST_EXEC) && !alu_done &&
                         (exec_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == ST_EXEC) exec_cnt <= exec_cnt + 1'b1;
            else                  exec_cnt <= '0;
            if (state == ST_EXEC) begin
                if (alu_done)         rsp_err_q <= 1'b0;
                else if (timeout_hit) rsp_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_EXEC;
            ST_EXEC: if (alu_done || timeout_hit) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath: capture the winner's command, hold it for the ALU, latch result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner     <= pick_idx;
                        alu_op    <= sel_op;
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_start <= 1'b1;
                        rr_ptr    <= rr_next;
                    end
                end
                ST_EXEC: begin
                    if (alu_done) begin
                        rsp_data  <= alu_out;
                        alu_start <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        alu_start <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int W    = NREQ + DW + 1;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [3*NREQ-1:0]  req_op;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [2:0]         alu_op;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic               alu_start;
  logic               alu_done;
  logic [DW-1:0]      alu_out;
  logic               busy;

  alu_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- ALU responder ----------------
  int alu_lat  = 2;   // cycles of alu_start before done; 0 = never
  bit alu_auto = 1'b1;
  int alu_cnt  = 0;

  function automatic logic [DW-1:0] alu_calc(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b011:  return (b == 0) ? '0 : a / b;
      default: return '0;
    endcase
  endfunction

  initial begin
    alu_done = 1'b0;
    alu_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_auto) begin
        if (alu_start && alu_lat != 0) begin
          alu_cnt++;
          if (alu_cnt == alu_lat) begin
            alu_done = 1'b1;
            alu_out  = alu_calc(alu_op, alu_a, alu_b);
          end else begin
            alu_done = 1'b0;
          end
        end else begin
          alu_cnt  = 0;
          alu_done = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int idx, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] exp_d,
                       input logic exp_e, input bit push, output int waited);
    int n;
    logic [NREQ-1:0] oh;
    n  = 0;
    oh = '0;
    oh[idx] = 1'b1;
    req_op[3*idx +: 3]  = op;
    req_a[DW*idx +: DW] = a;
    req_b[DW*idx +: DW] = b;
    req_valid[idx]      = 1'b1;
    #1;
    while (!req_ready[idx] && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    waited = n;
    checks++;
    if (!req_ready[idx]) begin
      errors++;
      $display("FAIL accept_req%0d: req_ready=%b never granted, expected grant", idx, req_ready);
      req_valid[idx] = 1'b0;
    end else begin
      if (push) exp_q.push_back({oh, exp_d, exp_e});
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("reset_ctrl", {req_ready, rsp_valid, alu_start, busy, rsp_err}, 0);
    chk("reset_data", {rsp_data, alu_a}, 0);
    chk("reset_rr_ptr", dut.rr_ptr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_got, mon_exp;
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      checks++;
      mon_got = {rsp_valid, rsp_data, rsp_err};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b data=%h err=%b, expected no response",
                 rsp_valid, rsp_data, rsp_err);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL rsp: got valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
                   rsp_valid, rsp_data, rsp_err,
                   mon_exp[W-1 -: NREQ], mon_exp[DW:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int waited, found, starts;
    logic [NREQ-1:0] exp_g;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    reset     = 1'b0;
    do_reset();

    // 1: single ADD 5+3, ALU done after 2 cycles
    alu_lat = 2;
    issue(0, OP_ADD, 16'd5, 16'd3, 16'd8, 1'b0, 1'b1, waited);
    found  = -1;
    starts = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[0] && found < 0) found = k;
      if (alu_start) starts++;
      @(posedge clk); #1;
    end
    chk("t1_rsp_cycle", found, 2);
    chk("t1_start_cycles", starts, 2);
    chk("t1_busy_after", busy, 0);
    wait_drain("t1_drain");

    // 2: both requesters held valid from reset, grants alternate 0,1,0,1
    do_reset();
    req_op[0 +: 3]  = OP_ADD; req_a[0 +: DW]  = 16'd10; req_b[0 +: DW]  = 16'd1;
    req_op[3 +: 3]  = OP_SUB; req_a[DW +: DW] = 16'd10; req_b[DW +: DW] = 16'd1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (req_ready == '0 && n < 100) begin
        @(posedge clk); #2;
        n++;
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("t2_grant", req_ready, exp_g);
      exp_q.push_back({exp_g, (k % 2 == 0) ? 16'd11 : 16'd9, 1'b0});
      @(posedge clk); #2;
      chk("t2_rr_ptr", dut.rr_ptr, (k % 2 == 0) ? 1 : 0);
    end
    req_valid = '0;
    wait_drain("t2_drain");

    // 3: only req1 valid with rr_ptr 0 -> granted with no idle cycle
    do_reset();
    issue(1, OP_MUL, 16'd3, 16'd4, 16'd12, 1'b0, 1'b1, waited);
    chk("t3_wait_cycles", waited, 0);
    wait_drain("t3_drain");

    // 4: alu_done while idle is ignored
    alu_auto = 1'b0;
    alu_done = 1'b1;
    alu_out  = 16'h1234;
    @(posedge clk); #1;
    alu_done = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy", busy, 0);
    @(posedge clk); #1;
    chk("t4_state_idle", busy, 0);
    alu_auto = 1'b1;

    // 5: reset during EXEC of MUL 7*6 discards the operation
    alu_lat = 20;
    issue(0, OP_MUL, 16'd7, 16'd6, 16'd0, 1'b0, 1'b0, waited);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_alu_op", alu_op, OP_MUL);
    chk("t5_alu_ab", {alu_a, alu_b}, {16'd7, 16'd6});
    chk("t5_exec", {busy, alu_start}, 2'b11);
    reset = 1'b1;
    #1;
    chk("t5_reset_ctrl", {req_ready, rsp_valid, alu_start, busy, rsp_err}, 0);
    chk("t5_reset_data", {rsp_data, alu_a, alu_b}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b0;
    alu_lat = 2;
    issue(0, OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0, 1'b1, waited);
    chk("t5_next_accept", waited, 0);
    wait_drain("t5_drain");

`ifdef ALU_ARB_TIMEOUT_EN
    // 6: ALU never completes -> abort after 8 EXEC cycles
    alu_lat = 0;
    issue(0, OP_ADD, 16'd4, 16'd4, 16'd0, 1'b1, 1'b1, waited);
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      if (alu_start) starts++;
      @(posedge clk); #1;
    end
    chk("t6_exec_cycles", starts, 8);
    wait_drain("t6_drain_abort");
    // done in the expiry cycle wins
    alu_lat = 8;
    issue(1, OP_ADD, 16'd4, 16'd4, 16'd8, 1'b0, 1'b1, waited);
    wait_drain("t6_drain_edge");
`else
    // long ALU latency completes normally when no abort is built in
    alu_lat = 70;
    issue(1, OP_DIV, 16'd100, 16'd7, 16'd14, 1'b0, 1'b1, waited);
    wait_drain("t6_drain_long");
`endif
    alu_lat = 2;

    // final outstanding check
    wait_drain("final_drain");
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
